// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: drains the receiver holding register into a tagged
// receive FIFO, tracks overrun and raises the threshold interrupt.
module uart_rx_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       rsr_full_i,
  input  logic       rsr_empty_i,
  input  logic [7:0] rsr_byte_i,
  input  logic       ferr_i,
  input  logic       perr_i,
  output logic       rsr_pull_o,
  input  logic       rd_i,
  input  logic       oerr_clr_i,
  input  logic [1:0] rxisel_i,
  output logic [7:0] rx_data_o,
  output logic       rx_ferr_o,
  output logic       rx_perr_o,
  output logic       rx_avail_o,
  output logic       oerr_o,
  output logic       rx_int_o,
  output logic       rx_idle_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          oerr_q, oerr_d;
  logic          int_q, int_d;

  logic flush;
  logic take;
  logic fifo_full;
  logic wr_en;
  logic rd_en;
  logic ovf_set;

  assign flush     = oerr_clr_i | ~enable_i;
  assign take      = enable_i & rsr_full_i & ~oerr_q;
  assign fifo_full = (count_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (take && !fifo_full) state_d = S_CAPTURE;
        end
        S_CAPTURE: state_d = S_WAIT;
        // hold until the receiver drops full so a byte is taken once
        S_WAIT: begin
          if (!rsr_full_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rsr_pull_o = (state_q == S_CAPTURE);
    wr_en      = (state_q == S_CAPTURE) & ~flush;
    ovf_set    = (state_q == S_IDLE) & take & fifo_full;
    rd_en      = rd_i & (count_q != '0) & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    oerr_d   = oerr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      oerr_d   = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (ovf_set) oerr_d = 1'b1;
    end
  end

  always_comb begin
    unique case (rxisel_i)
      2'b10:   int_d = (count_d >= CW'(DEPTH - 1));
      2'b11:   int_d = (count_d == CW'(DEPTH));
      default: int_d = (count_d != '0);
    endcase
    int_d = int_d & enable_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      oerr_q   <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      oerr_q   <= oerr_d;
      int_q    <= int_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= {perr_i, ferr_i, rsr_byte_i};
    end
  end

  assign {rx_perr_o, rx_ferr_o, rx_data_o} = mem_q[rd_ptr_q];
  assign rx_avail_o = (count_q != '0);
  assign oerr_o     = oerr_q;
  assign rx_int_o   = int_q;
  assign rx_idle_o  = rsr_empty_i & ~rx_avail_o;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed vector tables plus hand-written
// sequences for capture, overrun, streaming and reset behaviour.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rsr_full;
  logic       rsr_empty;
  logic [7:0] rsr_byte;
  logic       ferr;
  logic       perr;
  logic       rsr_pull;
  logic       rd;
  logic       oerr_clr;
  logic [1:0] rxisel;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rx_perr;
  logic       rx_avail;
  logic       oerr;
  logic       rx_int;
  logic       rx_idle;

  int tests = 0;
  int fails = 0;

  uart_rx_ctrl #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .rsr_full_i (rsr_full),
    .rsr_empty_i(rsr_empty),
    .rsr_byte_i (rsr_byte),
    .ferr_i     (ferr),
    .perr_i     (perr),
    .rsr_pull_o (rsr_pull),
    .rd_i       (rd),
    .oerr_clr_i (oerr_clr),
    .rxisel_i   (rxisel),
    .rx_data_o  (rx_data),
    .rx_ferr_o  (rx_ferr),
    .rx_perr_o  (rx_perr),
    .rx_avail_o (rx_avail),
    .oerr_o     (oerr),
    .rx_int_o   (rx_int),
    .rx_idle_o  (rx_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       f;
    logic       p;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } tag_vec_t;

  typedef struct {
    logic [1:0] sel;
    int         n;
    logic       exp_int;
    logic       exp_int_rd;
  } thr_vec_t;

  tag_vec_t tag_tbl [3];
  thr_vec_t thr_tbl [7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Raise full and wait (bounded) until the pull is seen at a negedge.
  task automatic wait_pull(output bit got);
    got = 1'b0;
    rsr_full  = 1'b1;
    rsr_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsr_pull) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("pull_timeout", 0, 1);
  endtask

  // Receiver model: present a byte, clear on pull, return with FSM idle.
  task automatic push(input logic [7:0] b, input logic f, input logic p);
    bit got;
    rsr_byte = b;
    ferr     = f;
    perr     = p;
    wait_pull(got);
    rsr_full  = 1'b0;
    rsr_empty = 1'b1;
    tick();
    tick();
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic flush();
    oerr_clr = 1'b1;
    tick();
    oerr_clr = 1'b0;
  endtask

  initial begin
    bit got;
    int pulls;

    tag_tbl[0] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
    tag_tbl[1] = '{8'h22, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1};
    tag_tbl[2] = '{8'h33, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};

    thr_tbl[0] = '{2'b00, 1, 1'b1, 1'b0};
    thr_tbl[1] = '{2'b01, 2, 1'b1, 1'b1};
    thr_tbl[2] = '{2'b10, 2, 1'b0, 1'b0};
    thr_tbl[3] = '{2'b10, 3, 1'b1, 1'b0};
    thr_tbl[4] = '{2'b11, 3, 1'b0, 1'b0};
    thr_tbl[5] = '{2'b11, 4, 1'b1, 1'b0};
    thr_tbl[6] = '{2'b00, 0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    enable    = 1'b1;
    rsr_full  = 1'b0;
    rsr_empty = 1'b1;
    rsr_byte  = 8'h00;
    ferr      = 1'b0;
    perr      = 1'b0;
    rd        = 1'b0;
    oerr_clr  = 1'b0;
    rxisel    = 2'b00;
    #12;
    check("rst_pull", rsr_pull, 0);
    check("rst_oerr", oerr, 0);
    check("rst_int", rx_int, 0);
    check("rst_avail", rx_avail, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", rx_ferr, 0);
    check("rst_perr", rx_perr, 0);
    check("rst_idle", rx_idle, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // single byte with capture latency
    rsr_byte  = 8'hA5;
    rsr_full  = 1'b1;
    rsr_empty = 1'b0;
    tick();
    check("single_pull_n1", rsr_pull, 1);
    check("single_avail_n1", rx_avail, 0);
    rsr_full = 1'b0;
    tick();
    check("single_pull_n2", rsr_pull, 0);
    check("single_avail_n2", rx_avail, 1);
    check("single_data", rx_data, 8'hA5);
    check("single_int", rx_int, 1);
    check("single_idle_busy", rx_idle, 0);
    rsr_empty = 1'b1;
    tick();
    check("single_no_2nd_pull", rsr_pull, 0);
    pop();
    check("single_rd_avail", rx_avail, 0);
    check("single_rd_int", rx_int, 0);
    check("single_idle", rx_idle, 1);

    // error tagging table
    foreach (tag_tbl[i]) push(tag_tbl[i].b, tag_tbl[i].f, tag_tbl[i].p);
    foreach (tag_tbl[i]) begin
      check($sformatf("tag%0d_data", i), rx_data, tag_tbl[i].exp_data);
      check($sformatf("tag%0d_ferr", i), rx_ferr, tag_tbl[i].exp_ferr);
      check($sformatf("tag%0d_perr", i), rx_perr, tag_tbl[i].exp_perr);
      pop();
    end
    check("tag_empty", rx_avail, 0);

    // threshold table
    foreach (thr_tbl[i]) begin
      flush();
      rxisel = thr_tbl[i].sel;
      tick();
      for (int k = 0; k < thr_tbl[i].n; k++) push(8'h60 + 8'(k), 1'b0, 1'b0);
      check($sformatf("thr%0d_int", i), rx_int, thr_tbl[i].exp_int);
      check($sformatf("thr%0d_avail", i), rx_avail, thr_tbl[i].n > 0);
      pop();
      check($sformatf("thr%0d_int_rd", i), rx_int, thr_tbl[i].exp_int_rd);
    end
    check("thr_empty_rd_ignored", rx_avail, 0);

    // overrun
    flush();
    rxisel = 2'b00;
    for (int k = 0; k < 4; k++) push(8'h40 + 8'(k), 1'b0, 1'b0);
    rsr_byte  = 8'h44;
    rsr_full  = 1'b1;
    rsr_empty = 1'b0;
    tick();
    check("ovr_oerr_set", oerr, 1);
    pulls = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ovr_rd%0d", k), rx_data, 8'h40 + 8'(k));
      if (rsr_pull) pulls++;
      pop();
    end
    for (int k = 0; k < 4; k++) begin
      if (rsr_pull) pulls++;
      tick();
    end
    check("ovr_no_pull", pulls, 0);
    check("ovr_drained", rx_avail, 0);
    check("ovr_sticky", oerr, 1);
    flush();
    check("ovr_clr", oerr, 0);
    wait_pull(got);
    rsr_full  = 1'b0;
    rsr_empty = 1'b1;
    tick();
    check("ovr_5th_data", rx_data, 8'h44);
    check("ovr_5th_avail", rx_avail, 1);
    tick();

    // simultaneous write and read across pointer wrap
    flush();
    rxisel = 2'b10;
    push(8'h50, 1'b0, 1'b0);
    push(8'h51, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      rsr_byte = 8'h52 + 8'(k);
      wait_pull(got);
      rd        = 1'b1;
      rsr_full  = 1'b0;
      rsr_empty = 1'b1;
      tick();
      rd = 1'b0;
      check($sformatf("wr_rd%0d_head", k), rx_data, 8'h51 + 8'(k));
      check($sformatf("wr_rd%0d_int", k), rx_int, 0);
      tick();
    end
    check("wr_rd_tail0", rx_data, 8'h56);
    pop();
    check("wr_rd_tail1", rx_data, 8'h57);
    pop();
    check("wr_rd_empty", rx_avail, 0);

    // disable with full FIFO and overrun pending
    flush();
    rxisel = 2'b00;
    for (int k = 0; k < 4; k++) push(8'h70 + 8'(k), 1'b0, 1'b0);
    rsr_full  = 1'b1;
    rsr_empty = 1'b0;
    tick();
    check("dis_oerr_pre", oerr, 1);
    rsr_full  = 1'b0;
    rsr_empty = 1'b1;
    enable    = 1'b0;
    tick();
    check("dis_avail", rx_avail, 0);
    check("dis_int", rx_int, 0);
    check("dis_oerr", oerr, 0);
    enable = 1'b1;
    tick();

    // enable dropped during capture discards the write
    rsr_byte = 8'h81;
    wait_pull(got);
    enable    = 1'b0;
    rsr_full  = 1'b0;
    rsr_empty = 1'b1;
    tick();
    check("dis_cap_avail", rx_avail, 0);
    check("dis_cap_pull", rsr_pull, 0);
    enable = 1'b1;
    tick();

    // asynchronous reset during capture
    push(8'h9C, 1'b1, 1'b1);
    check("arst_pre_data", rx_data, 8'h9C);
    rsr_byte = 8'h9D;
    wait_pull(got);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pull", rsr_pull, 0);
    check("arst_avail", rx_avail, 0);
    check("arst_data", rx_data, 8'h00);
    check("arst_ferr", rx_ferr, 0);
    check("arst_perr", rx_perr, 0);
    check("arst_int", rx_int, 0);
    check("arst_oerr", oerr, 0);
    rsr_full  = 1'b0;
    rsr_empty = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. It drains the receiver's single-byte holding register (RSR) into a DEPTH-entry receive FIFO, tagging each entry with its framing and parity error flags. It detects overrun, generates the receive interrupt from a programmable fill threshold, and presents the FIFO head to the register interface for CPU reads. It sits between the receiver and the register block, and is the only agent driving the receiver's pull strobe.

## Interface
- DEPTH, 4, FIFO depth in entries; power of two, 2..16.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable_i  in  1  UART enable; low flushes FIFO, clears overrun and forces FSM to IDLE.
- rsr_full_i  in  1  receiver holds a complete byte.
- rsr_empty_i  in  1  receiver idle with no byte held.
- rsr_byte_i  in  8  received byte.
- ferr_i  in  1  framing error for held byte.
- perr_i  in  1  parity error for held byte.
- rsr_pull_o  out  1  one-cycle strobe; receiver clears RSR and flags on the next edge.
- rd_i  in  1  CPU read strobe; pops the FIFO head.
- oerr_clr_i  in  1  clears overrun and flushes the FIFO.
- rxisel_i  in  2  interrupt threshold select.
- rx_data_o  out  8  FIFO head byte.
- rx_ferr_o  out  1  FIFO head framing flag.
- rx_perr_o  out  1  FIFO head parity flag.
- rx_avail_o  out  1  FIFO not empty.
- oerr_o  out  1  sticky overrun flag.
- rx_int_o  out  1  receive interrupt, registered level.
- rx_idle_o  out  1  rsr_empty_i & FIFO empty.

## Operation
- FIFO storage: DEPTH × 10 bits {perr, ferr, byte}.
  - Write pointer, read pointer and count are registered; count is $clog2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
  - Head outputs are driven combinationally from storage at the read pointer; when empty they show the last value at that location.
- FSM states: IDLE, CAPTURE, WAIT.
  - IDLE → CAPTURE when enable_i & rsr_full_i & !oerr_o & count<DEPTH.
  - IDLE: when enable_i & rsr_full_i & !oerr_o & count==DEPTH, set oerr_o and stay in IDLE. No pull is issued; the byte stays in the RSR and the receiver's RTS throttles the remote end.
  - CAPTURE: rsr_pull_o=1; write {perr_i, ferr_i, rsr_byte_i} at the write pointer; go to WAIT.
  - WAIT → IDLE when !rsr_full_i. This prevents a double capture of the same byte.
- Read: rd_i with count>0 advances the read pointer. rd_i when empty is ignored, with no underflow.
- A write and a read in the same cycle both take effect; count is unchanged.
- Flush (oerr_clr_i, or enable_i low) resets pointers and count and clears oerr_o. Flush has priority over a same-cycle write and read; a byte pulled in that cycle is discarded.
- While oerr_o=1, no transfers occur even if the FIFO drains; only a flush resumes reception.
- rx_int_o is a registered function of the next count:
  - rxisel_i 00 or 01: count≥1.
  - rxisel_i 10: count≥DEPTH-1.
  - rxisel_i 11: count==DEPTH.
  - Forced 0 when enable_i is low.

## Timing
- Reset values:
  - rsr_pull_o=0, oerr_o=0, rx_int_o=0, rx_avail_o=0.
  - rx_data_o=0, rx_ferr_o=0, rx_perr_o=0.
  - rx_idle_o follows rsr_empty_i; FSM in IDLE; all storage 0.
- Capture latency: rsr_full_i seen high at edge N → CAPTURE in cycle N+1 (pull high) → entry visible, rx_avail_o=1 and count updated in cycle N+2. The interrupt is also high in cycle N+2.
- rsr_pull_o is never high for two consecutive cycles. Minimum spacing between pulls is 3 cycles.
- rd_i at edge M: the new head and count are visible in cycle M+1; rx_int_o is updated in the same cycle.
- oerr_o sets one cycle after rsr_full_i is seen with the FIFO full.
- enable_i falling mid-CAPTURE: pull still completes that cycle, the write is discarded, and the FSM goes to IDLE.
- Asynchronous reset mid-operation: all state clears immediately; rsr_pull_o drops without waiting for a clock.

## Test plan
- Single byte: hold rsr_full_i=1 with byte 0xA5, flags 0 → exactly one rsr_pull_o pulse. rx_avail_o=1 and rx_data_o=0xA5 two cycles later. rd_i → rx_avail_o=0, and rx_idle_o=1 once rsr_empty_i=1.
- Error tagging: bytes 0x11 (ferr=1), 0x22 (perr=1), 0x33 (clean) → reads return each head with matching rx_ferr_o and rx_perr_o, in order.
- Overrun: DEPTH=4, fill 4 bytes, then present a 5th → no 5th pull, oerr_o=1. Read all 4; still no pull. oerr_clr_i → FIFO empty, then the 5th byte is captured.
- Thresholds: rxisel_i=10 → rx_int_o rises on the 3rd entry. rxisel_i=11 → rises on the 4th. rxisel_i=00 → rises on the 1st and falls when the last entry is read.
- Simultaneous write and read with count=2: CAPTURE cycle coincides with rd_i → count stays 2 and FIFO order is preserved across pointer wrap (≥6 bytes streamed).
- Disable and reset: enable_i low with 3 entries → empty, rx_int_o=0, oerr_o=0. Assert rst_n low during CAPTURE → all outputs at reset values asynchronously.
